// File: rtl/decimal_key_entry_pkg.sv
// Shared calc package: key codes, FSM state encoding and signed-range limits
// used by decimal_key_entry.
package decimal_key_entry_pkg;

  localparam logic [3:0] KEY_SIGN  = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hD;

  localparam int unsigned POS_MAX = 127;
  localparam int unsigned NEG_MAX = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CONVERT = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } state_t;

endpackage

// File: rtl/decimal_key_entry_mul10.sv
// mul10_add_digit: combinational acc*10 + digit step of the decimal-to-binary
// conversion. Bit 9 of the result flags magnitudes that no longer fit in 9 bits.
module mul10_add_digit (
  input  logic [8:0] acc,
  input  logic [3:0] digit,
  output logic [9:0] result
);

  logic [9:0] acc_w;

  // acc never exceeds 99 while converting, so 10 bits hold the full result
  assign acc_w  = {1'b0, acc};
  assign result = (acc_w << 3) + (acc_w << 1) + {6'b0, digit};

endmodule

// File: rtl/decimal_key_entry.sv
// Decimal keypad entry: collects up to MAX_DIGITS BCD digits and a sign, then
// converts to an 8-bit signed value. Backspace support: define DEC_ENTRY_BACKSPACE_EN.
//
// state   | meaning
// IDLE    | buffer empty, waiting for keys
// ENTRY   | one or more digits typed
// CONVERT | folding digits MSB first into the accumulator, one per cycle
// DONE    | value loaded, value_valid pulsing for one cycle
// ERROR   | magnitude out of range, only clear is accepted
module decimal_key_entry
  import decimal_key_entry_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int KEY_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  output logic [7:0]       value,
  output logic             value_valid,
  output logic             busy,
  output logic             entry_err,
  output logic [3:0]       dig2,
  output logic [3:0]       dig1,
  output logic [3:0]       dig0,
  output logic             entry_neg
);

  state_t          state, state_nx;
  logic [2:0][3:0] digs, digs_nx;
  logic [1:0]      count, count_nx;
  logic [1:0]      conv_left, conv_left_nx;
  logic            neg, neg_nx;
  logic [8:0]      acc, acc_nx;
  logic [7:0]      value_nx;
  logic            value_valid_nx;
  logic [1:0]      conv_idx;
  logic [3:0]      conv_digit;
  logic [9:0]      mac;
  logic            is_digit;

  assign is_digit = key_code <= KEY_W'(9);

  // conv_left counts down from n, so the MSB sits at position conv_left-1
  assign conv_idx   = conv_left - 2'd1;
  assign conv_digit = (conv_idx == 2'd2) ? digs[2] :
                      (conv_idx == 2'd1) ? digs[1] : digs[0];

  mul10_add_digit u_mul10 (
    .acc   (acc),
    .digit (conv_digit),
    .result(mac)
  );

  always_comb begin
    state_nx       = state;
    digs_nx        = digs;
    count_nx       = count;
    neg_nx         = neg;
    conv_left_nx   = conv_left;
    acc_nx         = acc;
    value_nx       = value;
    value_valid_nx = 1'b0;
    case (state)
      IDLE, ENTRY: begin
        if (key_valid) begin
          if (is_digit) begin
            if (count < 2'(MAX_DIGITS)) begin
              digs_nx  = {digs[1:0], key_code[3:0]};
              count_nx = count + 2'd1;
              state_nx = ENTRY;
            end
          end else if (key_code == KEY_W'(KEY_SIGN)) begin
            neg_nx = ~neg;
          end else if (key_code == KEY_W'(KEY_CLR)) begin
            digs_nx  = '0;
            count_nx = '0;
            neg_nx   = 1'b0;
            state_nx = IDLE;
          end else if (key_code == KEY_W'(KEY_ENTER) && count != 2'd0) begin
            conv_left_nx = count;
            acc_nx       = '0;
            state_nx     = CONVERT;
          end
`ifdef DEC_ENTRY_BACKSPACE_EN
          else if (key_code == KEY_W'(KEY_BKSP) && state == ENTRY) begin
            digs_nx  = {4'h0, digs[2:1]};
            count_nx = count - 2'd1;
            if (count == 2'd1) state_nx = IDLE;
          end
`endif
        end
      end
      CONVERT: begin
        acc_nx       = mac[8:0];
        conv_left_nx = conv_left - 2'd1;
        if (conv_left == 2'd1) begin
          if (neg ? (mac > 10'(NEG_MAX)) : (mac > 10'(POS_MAX))) begin
            state_nx = ERROR;
          end else begin
            value_nx       = neg ? (~mac[7:0] + 8'd1) : mac[7:0];
            value_valid_nx = 1'b1;
            state_nx       = DONE;
          end
        end
      end
      DONE: begin
        digs_nx  = '0;
        count_nx = '0;
        neg_nx   = 1'b0;
        state_nx = IDLE;
      end
      ERROR: begin
        if (key_valid && key_code == KEY_W'(KEY_CLR)) begin
          digs_nx  = '0;
          count_nx = '0;
          neg_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      digs        <= '0;
      count       <= '0;
      neg         <= 1'b0;
      conv_left   <= '0;
      acc         <= '0;
      value       <= '0;
      value_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      digs        <= digs_nx;
      count       <= count_nx;
      neg         <= neg_nx;
      conv_left   <= conv_left_nx;
      acc         <= acc_nx;
      value       <= value_nx;
      value_valid <= value_valid_nx;
    end
  end

  assign dig2      = digs[2];
  assign dig1      = digs[1];
  assign dig0      = digs[0];
  assign entry_neg = neg;
  assign busy      = (state == CONVERT) || (state == DONE);
  assign entry_err = (state == ERROR);

endmodule

// File: tb/tb_decimal_key_entry.sv
// Randomized self-checking bench for decimal_key_entry against a key-level
// reference model (digit queue, sign, error flag, last value).
module tb_decimal_key_entry;

  localparam int MAXD = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] value;
  logic       value_valid, busy, entry_err, entry_neg;
  logic [3:0] dig2, dig1, dig0;

  decimal_key_entry dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .value      (value),
    .value_valid(value_valid),
    .busy       (busy),
    .entry_err  (entry_err),
    .dig2       (dig2),
    .dig1       (dig1),
    .dig0       (dig0),
    .entry_neg  (entry_neg)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int q[$];
  bit m_neg, m_err;
  int m_value;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qdig(input int pos);
    if (q.size() > pos) return q[q.size() - 1 - pos];
    return 0;
  endfunction

  task automatic check_static(input string tag);
    chk({tag, ".dig0"}, int'(dig0), qdig(0));
    chk({tag, ".dig1"}, int'(dig1), qdig(1));
    chk({tag, ".dig2"}, int'(dig2), qdig(2));
    chk({tag, ".neg"}, int'(entry_neg), int'(m_neg));
    chk({tag, ".err"}, int'(entry_err), int'(m_err));
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".vv"}, int'(value_valid), 0);
    chk({tag, ".value"}, int'(value), m_value);
  endtask

  task automatic model_reset();
    q.delete();
    m_neg = 0;
    m_err = 0;
    m_value = 0;
  endtask

  task automatic model_key(input int k);
    if (m_err) begin
      if (k == 12) begin q.delete(); m_neg = 0; m_err = 0; end
      return;
    end
    if (k <= 9) begin
      if (q.size() < MAXD) q.push_back(k);
    end else if (k == 10) begin
      m_neg = !m_neg;
    end else if (k == 12) begin
      q.delete(); m_neg = 0;
    end
`ifdef DEC_ENTRY_BACKSPACE_EN
    else if (k == 11) begin
      if (q.size() > 0) void'(q.pop_back());
    end
`endif
  endtask

  // starts and ends on a falling edge
  task automatic press(input int k);
    key_valid = 1'b1;
    key_code  = 4'(k);
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'($urandom);
  endtask

  // inj: 0 none, 1 inject inj_k in the first busy cycle, 2 random injections
  task automatic do_key(input string tag, input int k, input int inj, input int inj_k);
    int n, mag, exp_v, c;
    bit over;
    press(k);
    if (k == 13 && !m_err && q.size() > 0) begin
      n = q.size();
      mag = 0;
      foreach (q[i]) mag = mag * 10 + q[i];
      over = m_neg ? (mag > 128) : (mag > 127);
      exp_v = m_neg ? ((256 - mag) & 255) : mag;
      for (c = 1; c <= n + (over ? 0 : 1); c++) begin
        chk({tag, ".busy_run"}, int'(busy), 1);
        chk({tag, ".vv_run"}, int'(value_valid), (c == n + 1) ? 1 : 0);
        if (c == n + 1) chk({tag, ".value_out"}, int'(value), exp_v);
        if ((inj == 1 && c == 1) || (inj == 2 && $urandom_range(0, 1) == 1)) begin
          key_valid = 1'b1;
          key_code  = (inj == 1) ? 4'(inj_k) : 4'($urandom);
        end
        @(negedge clk);
        key_valid = 1'b0;
      end
      if (over) m_err = 1;
      else begin m_value = exp_v; q.delete(); m_neg = 0; end
    end else begin
      model_key(k);
    end
    check_static(tag);
  endtask

  task automatic keys(input string tag, input int ks[$]);
    foreach (ks[i]) do_key(tag, ks[i], 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_static("reset");

    keys("r031", '{1, 2, 7, 13});
    chk("r031.value_7f", int'(value), 'h7F);

    keys("r032a", '{10, 1, 2, 8, 13});
    chk("r032a.value_80", int'(value), 'h80);
    keys("r032b", '{1, 2, 8, 13, 5, 13, 10});
    chk("r032b.err", int'(entry_err), 1);
    chk("r032b.value_hold", int'(value), 'h80);
    keys("r032c", '{12});
    chk("r032c.err_clr", int'(entry_err), 0);

    keys("r033", '{5});
    do_key("r033", 13, 1, 9);
    chk("r033.value_05", int'(value), 5);
    chk("r033.dig0_dropped", int'(dig0), 0);

    keys("r034", '{4, 2, 1, 3});
    chk("r034.digits", int'({dig2, dig1, dig0}), 'h421);
    keys("r034", '{13});
    chk("r034.err", int'(entry_err), 1);
    keys("r034", '{12});

    keys("r035", '{1, 2, 11, 9, 13});
`ifdef DEC_ENTRY_BACKSPACE_EN
    chk("r035.value_19", int'(value), 19);
`else
    chk("r035.err_129", int'(entry_err), 1);
`endif
    keys("r035", '{12});

    keys("r021", '{10, 0, 13});
    chk("r021.minus_zero", int'(value), 0);

    // reset during the second CONVERT cycle of 99
    keys("r036", '{9, 9});
    key_valid = 1'b1;
    key_code  = 4'hD;
    @(negedge clk);
    key_valid = 1'b0;
    chk("r036.busy_c1", int'(busy), 1);
    @(negedge clk);
    chk("r036.busy_c2", int'(busy), 1);
    reset = 1'b1;
    #1;
    model_reset();
    chk("r036.busy0", int'(busy), 0);
    chk("r036.value0", int'(value), 0);
    chk("r036.digs0", int'({dig2, dig1, dig0}), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("r036.no_pulse", int'(value_valid), 0);
    end
    check_static("r036");

    for (int i = 0; i < 400; i++) begin
      int k;
      k = $urandom_range(0, 15);
      do_key("rand", k, 2, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) check_static("rand_gap");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decimal_key_entry.md
DECIMAL_KEY_ENTRY -- requirements
Module: decimal_key_entry

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 3, giving the maximum number of decimal digits held in the entry buffer (legal range 1..3).
REQ-002 SHALL have parameter KEY_W, default 4, giving the width of the key code.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port key_valid, input, 1 bit: one-cycle strobe qualifying key_code (already debounced upstream).
REQ-007 SHALL have port key_code, input, KEY_W bits: 0-9 are digits, A is sign toggle, B is backspace, C is clear, D is enter, and E-F are ignored.
REQ-008 SHALL have port value, output, 8 bits: signed two's-complement result of the last successful entry.
REQ-009 SHALL have port value_valid, output, 1 bit: one-cycle pulse when value updates.
REQ-010 SHALL have port busy, output, 1 bit: high while converting or presenting a result; keys are ignored while it is high.
REQ-011 SHALL have port entry_err, output, 1 bit: high while in the ERROR state.
REQ-012 SHALL have ports dig2, dig1, dig0, outputs, 4 bits each: live BCD of the typed digits, right-justified, with unused positions 0.
REQ-013 SHALL have port entry_neg, output, 1 bit: current sign of the entry (1 means negative).

Function
REQ-014 SHALL implement states IDLE, ENTRY, CONVERT, DONE and ERROR.
REQ-015 SHALL, on a digit key in IDLE or ENTRY with count<MAX_DIGITS, shift the buffer left, insert the digit in dig0, increment count and go to ENTRY; a digit key at count==MAX_DIGITS SHALL be ignored.
REQ-016 SHALL toggle entry_neg on the sign key in IDLE or ENTRY, with no change to the digits.
REQ-017 SHALL, on the clear key in any state except CONVERT, zero the buffer, count and entry_neg, deassert entry_err and go to IDLE.
REQ-018 SHALL ignore the enter key when count==0; with count=n>0, an enter accepted at cycle T SHALL cause CONVERT to run during T+1..T+n, processing one digit per cycle as acc = acc*10 + digit, MSB first, with a 9-bit unsigned accumulator.
REQ-019 SHALL, at the end of CONVERT, go to ERROR with value unchanged and no pulse if the magnitude exceeds 127 (positive) or 128 (negative).
REQ-020 SHALL otherwise load value with the magnitude, or its two's-complement negation if entry_neg, and pulse value_valid in cycle T+n+1 while in DONE.
REQ-021 SHALL treat -0 as value 0 with no error.
REQ-022 SHALL go from DONE to IDLE after exactly one cycle, clearing the buffer, count and entry_neg; value SHALL hold until the next successful entry.
REQ-023 SHALL, in ERROR, hold the digits and entry_neg for display and accept only the clear key.
REQ-024 SHALL drive busy high exactly in CONVERT and DONE; a key_valid arriving in those states SHALL be dropped, not queued.
REQ-025 SHALL ignore undefined key codes in all states.

Reset
REQ-026 SHALL, on reset at any time including mid-CONVERT, asynchronously force state=IDLE, value=0, value_valid=0, busy=0, entry_err=0, entry_neg=0, dig2..dig0=0, count=0 and accumulator=0.

Configuration
REQ-027 SHALL, when DEC_ENTRY_BACKSPACE_EN is defined, make the backspace key in ENTRY shift the buffer right, zero the top position and decrement count, returning to IDLE when count reaches 0 (entry_neg is retained).
REQ-028 SHALL, when DEC_ENTRY_BACKSPACE_EN is undefined, ignore key code B in all states and omit the related logic.

Structure
REQ-029 SHALL take the key code constants (KEY_SIGN, KEY_BKSP, KEY_CLR, KEY_ENTER), the state encoding and the limits POS_MAX=127 and NEG_MAX=128 from the shared calc package.
REQ-030 SHALL use one combinational sub-module, mul10_add_digit, computing acc*10+digit, with 9-bit input, 4-bit digit and 10-bit output carrying the overflow bit.

Verification
REQ-031 SHALL be verified with keys 1,2,7,enter -> busy for 4 cycles, value=8'h7F with a value_valid pulse at T+4, then IDLE and digits cleared.
REQ-032 SHALL be verified with keys sign,1,2,8,enter -> value=8'h80 with a value_valid pulse; keys 1,2,8,enter (positive) -> entry_err=1, value holds 8'h80, and only clear exits.
REQ-033 SHALL be verified with keys 5,enter then 9 injected during CONVERT -> value=8'h05 at T+2, and the 9 is dropped (dig0=0 afterwards).
REQ-034 SHALL be verified with keys 4,2,1,3 -> digits show 4,2,1 and the fourth key is ignored; enter -> ERROR (421>127).
REQ-035 SHALL be verified with DEC_ENTRY_BACKSPACE_EN defined: keys 1,2,backspace,9,enter -> value=8'd19; undefined: the same sequence -> ERROR (129>127).
REQ-036 SHALL be verified with reset asserted in the second CONVERT cycle of entry 99 -> all outputs 0 immediately and no value_valid pulse.
